ray_sphere_intersector: RTL and testbench

- Consumer end of the ray-generator stream. Accepts one ray at a time (direction plus pixel index) over a valid/ready handshake and tests it against a single sphere.
- Emits one pixel result (index, hit flag, colour) per ray to the framebuffer writer over a second valid/ready handshake.
- Its in_ready drives the generator's ready_internal, which throttles ray issue.

---
 rtl/ray_sphere_intersector.sv | 137 +++++++++++++
 tb/tb_ray_sphere_intersector.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ray_sphere_intersector.sv
// ray_sphere_intersector: tests one ray per transaction against a single sphere and
// emits a pixel result with hit flag, colour, frame-last flag and running frame hit count.
module ray_sphere_intersector #(
  parameter int          DIR_W      = 16,
  parameter logic [7:0]  HIT_COLOUR = 8'hFF,
  parameter logic [7:0]  BG_COLOUR  = 8'h00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] ray_dir_x,
  input  logic [31:0] ray_dir_y,
  input  logic [31:0] ray_dir_z,
  input  logic [31:0] pixel_index,
  input  logic [10:0] camera_pos_x,
  input  logic [10:0] camera_pos_y,
  input  logic [10:0] camera_pos_z,
  input  logic [10:0] sphere_x,
  input  logic [10:0] sphere_y,
  input  logic [10:0] sphere_z,
  input  logic [10:0] sphere_r,
  input  logic [12:0] image_width,
  input  logic [12:0] image_height,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_index,
  output logic        out_hit,
  output logic [7:0]  out_colour,
  output logic        out_frame_last,
  output logic [31:0] hit_count
);
  localparam int PW = 2*DIR_W+4;
  localparam int DW = 4*DIR_W+10;
  typedef enum logic [1:0] {IDLE, DOT, DISC, OUT} state_t;
  state_t state;
  logic signed [DIR_W-1:0] dx_q, dy_q, dz_q;
  logic [31:0] idx_q;
  logic signed [10:0] cx_q, cy_q, cz_q, sx_q, sy_q, sz_q;
  logic [10:0] r_q;
  logic [25:0] wh_q;
  logic signed [PW-1:0] a_q, b_q, c_q;
  logic signed [PW-1:0] dxe, dye, dze, oxe, oye, oze, re, a_n, b_n, c_n;
  logic signed [11:0] ox, oy, oz;
  logic signed [DW-1:0] ae, be, ce, disc;
  logic hit, last;
  logic unused_dir_bits;
  assign in_ready = state == IDLE;
  assign unused_dir_bits = ^{ray_dir_x[31:DIR_W], ray_dir_y[31:DIR_W], ray_dir_z[31:DIR_W]};
  always_comb begin
    ox = {sx_q[10], sx_q} - {cx_q[10], cx_q};
    oy = {sy_q[10], sy_q} - {cy_q[10], cy_q};
    oz = {sz_q[10], sz_q} - {cz_q[10], cz_q};
    dxe = dx_q;
    dye = dy_q;
    dze = dz_q;
    oxe = ox;
    oye = oy;
    oze = oz;
    re = {{(PW-11){1'b0}}, r_q};
    a_n = dxe*dxe + dye*dye + dze*dze;
    b_n = dxe*oxe + dye*oye + dze*oze;
    c_n = oxe*oxe + oye*oye + oze*oze - re*re;
    ae = a_q;
    be = b_q;
    ce = c_q;
    disc = be*be - ae*ce;
    // b must be strictly positive: the sphere has to lie in front of the camera
    hit = b_q > 0 && disc >= 0;
    last = wh_q != '0 && idx_q == {6'd0, wh_q};
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      dx_q <= '0;
      dy_q <= '0;
      dz_q <= '0;
      idx_q <= '0;
      cx_q <= '0;
      cy_q <= '0;
      cz_q <= '0;
      sx_q <= '0;
      sy_q <= '0;
      sz_q <= '0;
      r_q <= '0;
      wh_q <= '0;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_hit <= 1'b0;
      out_colour <= BG_COLOUR;
      out_frame_last <= 1'b0;
      hit_count <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          dx_q <= ray_dir_x[DIR_W-1:0];
          dy_q <= ray_dir_y[DIR_W-1:0];
          dz_q <= ray_dir_z[DIR_W-1:0];
          idx_q <= pixel_index;
          cx_q <= camera_pos_x;
          cy_q <= camera_pos_y;
          cz_q <= camera_pos_z;
          sx_q <= sphere_x;
          sy_q <= sphere_y;
          sz_q <= sphere_z;
          r_q <= sphere_r;
          wh_q <= image_width * image_height;
          state <= DOT;
        end
        DOT: begin
          a_q <= a_n;
          b_q <= b_n;
          c_q <= c_n;
          state <= DISC;
        end
        DISC: begin
          out_index <= idx_q;
          out_hit <= hit;
          out_colour <= hit ? HIT_COLOUR : BG_COLOUR;
          out_frame_last <= last;
          hit_count <= hit_count + {31'd0, hit};
          out_valid <= 1'b1;
          state <= OUT;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          if (out_frame_last) hit_count <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ray_sphere_intersector.sv
// tb_ray_sphere_intersector: directed and random rays against a plain-arithmetic
// reference model, with a queue-based scoreboard checked by an independent monitor.
module tb_ray_sphere_intersector;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic in_valid, in_ready, out_valid, out_ready, out_hit, out_frame_last;
  logic [31:0] ray_dir_x, ray_dir_y, ray_dir_z, pixel_index, out_index, hit_count;
  logic [10:0] camera_pos_x, camera_pos_y, camera_pos_z, sphere_x, sphere_y, sphere_z, sphere_r;
  logic [12:0] image_width, image_height;
  logic [7:0] out_colour;
  always #5 clk = ~clk;

  ray_sphere_intersector dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .ray_dir_x(ray_dir_x), .ray_dir_y(ray_dir_y), .ray_dir_z(ray_dir_z),
    .pixel_index(pixel_index),
    .camera_pos_x(camera_pos_x), .camera_pos_y(camera_pos_y), .camera_pos_z(camera_pos_z),
    .sphere_x(sphere_x), .sphere_y(sphere_y), .sphere_z(sphere_z), .sphere_r(sphere_r),
    .image_width(image_width), .image_height(image_height),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index), .out_hit(out_hit),
    .out_colour(out_colour), .out_frame_last(out_frame_last), .hit_count(hit_count)
  );

  typedef struct {
    logic [31:0] dx, dy, dz, idx;
    logic [10:0] cx, cy, cz, sx, sy, sz, r;
    logic [12:0] w, h;
  } ray_t;
  typedef struct {
    logic [31:0] idx;
    logic hit;
    logic [7:0] col;
    logic last;
    logic [31:0] hc;
    int acc;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0, n_err = 0, cyc = 0, bp_mode = 0;
  logic [31:0] hc_m = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input ray_t r);
    exp_t e;
    longint dx, dy, dz, ox, oy, oz, rr, a, b, c, disc, wh;
    dx = longint'(shortint'(r.dx[15:0]));
    dy = longint'(shortint'(r.dy[15:0]));
    dz = longint'(shortint'(r.dz[15:0]));
    ox = longint'($signed(r.sx)) - longint'($signed(r.cx));
    oy = longint'($signed(r.sy)) - longint'($signed(r.cy));
    oz = longint'($signed(r.sz)) - longint'($signed(r.cz));
    rr = longint'(r.r);
    a = dx*dx + dy*dy + dz*dz;
    b = dx*ox + dy*oy + dz*oz;
    c = ox*ox + oy*oy + oz*oz - rr*rr;
    disc = b*b - a*c;
    wh = longint'(r.w) * longint'(r.h);
    e.idx = r.idx;
    e.hit = b > 0 && disc >= 0;
    e.col = e.hit ? 8'hFF : 8'h00;
    e.last = wh != 0 && longint'(r.idx) == wh;
    e.hc = '0;
    e.acc = 0;
    return e;
  endfunction

  function automatic ray_t mk(input int dx, dy, dz, idx, sx, sy, sz, r, w, h);
    ray_t t;
    t.dx = 32'(dx); t.dy = 32'(dy); t.dz = 32'(dz); t.idx = 32'(idx);
    t.cx = '0; t.cy = '0; t.cz = '0;
    t.sx = 11'(sx); t.sy = 11'(sy); t.sz = 11'(sz); t.r = 11'(r);
    t.w = 13'(w); t.h = 13'(h);
    return t;
  endfunction

  function automatic ray_t rnd_ray();
    ray_t t;
    logic [31:0] ux, uy, uz;
    int ox, oy, oz;
    t.cx = 11'($urandom); t.cy = 11'($urandom); t.cz = 11'($urandom);
    t.sx = 11'($urandom); t.sy = 11'($urandom); t.sz = 11'($urandom);
    t.r = 11'($urandom_range(0, 1500));
    ux = $urandom; uy = $urandom; uz = $urandom;
    ox = int'($signed(t.sx)) - int'($signed(t.cx));
    oy = int'($signed(t.sy)) - int'($signed(t.cy));
    oz = int'($signed(t.sz)) - int'($signed(t.cz));
    if ($urandom_range(0, 1) == 1) begin
      ux[15:0] = 16'(ox + int'($urandom_range(0, 200)) - 100);
      uy[15:0] = 16'(oy + int'($urandom_range(0, 200)) - 100);
      uz[15:0] = 16'(oz + int'($urandom_range(0, 200)) - 100);
    end
    t.dx = ux; t.dy = uy; t.dz = uz;
    t.w = 13'($urandom_range(0, 8));
    t.h = 13'($urandom_range(0, 8));
    t.idx = 32'($urandom_range(0, 70));
    return t;
  endfunction

  task automatic drive(input ray_t r);
    ray_dir_x = r.dx; ray_dir_y = r.dy; ray_dir_z = r.dz; pixel_index = r.idx;
    camera_pos_x = r.cx; camera_pos_y = r.cy; camera_pos_z = r.cz;
    sphere_x = r.sx; sphere_y = r.sy; sphere_z = r.sz; sphere_r = r.r;
    image_width = r.w; image_height = r.h;
    in_valid = 1'b1;
  endtask

  task automatic accept_now(input ray_t r);
    exp_t e;
    e = model(r);
    hc_m = hc_m + {31'd0, e.hit};
    e.hc = hc_m;
    if (e.last) hc_m = '0;
    e.acc = cyc;
    q.push_back(e);
    in_valid = 1'b0;
    ray_dir_x = $urandom; sphere_r = 11'($urandom);
  endtask

  task automatic wait_accept(input ray_t r);
    int n = 0;
    @(negedge clk);
    while (!in_ready) begin
      if (++n > 200) begin
        n_err++;
        $display("FAIL accept_timeout: in_ready stuck at %0b, required 1", in_ready);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $fatal(1);
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    accept_now(r);
  endtask

  task automatic send(input ray_t r);
    drive(r);
    wait_accept(r);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = bp_mode == 0 ? 1'b1 : bp_mode == 1 ? 1'b0 : 1'($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    bit seen = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_out_valid", 64'(out_valid), 64'd0);
        else begin
          if (!seen) chk("latency", 64'(cyc - q[0].acc), 64'd2);
          seen = 1'b1;
          chk("out_index", 64'(out_index), 64'(q[0].idx));
          chk("out_hit", 64'(out_hit), 64'(q[0].hit));
          chk("out_colour", 64'(out_colour), 64'(q[0].col));
          chk("out_frame_last", 64'(out_frame_last), 64'(q[0].last));
          chk("hit_count", 64'(hit_count), 64'(q[0].hc));
          chk("in_ready_busy", 64'(in_ready), 64'd0);
          if (out_ready) begin
            void'(q.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    ray_t r, r2;
    in_valid = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_index", 64'(out_index), 64'd0);
    chk("rst_out_hit", 64'(out_hit), 64'd0);
    chk("rst_out_colour", 64'(out_colour), 64'h00);
    chk("rst_out_frame_last", 64'(out_frame_last), 64'd0);
    chk("rst_hit_count", 64'(hit_count), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    send(mk(0, 0, 1, 5, 0, 0, 100, 10, 10, 10));
    send(mk(0, 0, -1, 6, 0, 0, 100, 10, 10, 10));
    send(mk(1, 0, 0, 7, 0, 0, 100, 10, 10, 10));
    send(mk(20, 0, 100, 8, 0, 0, 100, 10, 10, 10));
    send(mk(10, 0, 100, 9, 0, 0, 100, 10, 10, 10));
    r = mk(0, 0, 1, 11, 0, 0, 100, 10, 10, 10);
    r.dx = 32'hABCD0000; r.dy = 32'h12340000; r.dz = 32'h5A5A0001;
    send(r);
    wait_drain();
    // held result with a second ray waiting upstream
    bp_mode = 1;
    @(posedge clk);
    #1;
    send(mk(0, 0, 1, 20, 0, 0, 100, 10, 10, 10));
    r2 = mk(0, 0, -1, 21, 0, 0, 100, 10, 10, 10);
    drive(r2);
    repeat (7) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    bp_mode = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_bp", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    accept_now(r2);
    wait_drain();
    // reset while the ray sits in DISC
    send(mk(0, 0, 1, 30, 0, 0, 100, 10, 10, 10));
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_hit_count", 64'(hit_count), 64'd0);
    void'(q.pop_back());
    hc_m = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send(mk(0, 0, 1, 1, 0, 0, 100, 10, 2, 2));
    send(mk(0, 0, -1, 2, 0, 0, 100, 10, 2, 2));
    send(mk(0, 0, 1, 3, 0, 0, 100, 10, 2, 2));
    send(mk(0, 0, 1, 4, 0, 0, 100, 10, 2, 2));
    send(mk(0, 0, 1, 9, 0, 0, 100, 10, 2, 2));
    send(mk(0, 0, 1, 0, 0, 0, 100, 10, 0, 5));
    send(mk(0, 0, 1, 0, 0, 0, 100, 10, 7, 0));
    wait_drain();
    bp_mode = 2;
    for (int i = 0; i < 300; i++) send(rnd_ray());
    bp_mode = 0;
    wait_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
